// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single data-memory port between the IFU (read-only fetch) and
// the LSU (loads/stores). One outstanding transaction at a time, valid/ready
// on both request and response channels, plus a timeout watchdog that forces
// an error completion (rdata 0xDEADBEEF, rsp_err=1) if the slave hangs.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   ifu_req_*/ifu_rsp_*            fetch master request/response handshake
//   lsu_req_*/lsu_rsp_*            load/store master request/response handshake
//   rsp_rdata, rsp_err             shared response payload for both masters
//   mem_req_*                      registered request to the memory wrapper
//   mem_rsp_*                      response from the memory wrapper
//   busy                           arbiter is not idle
//
// Configuration macro: ARB_RR_EN
//   defined   : round-robin on contention (the master not granted last wins)
//   undefined : fixed priority, LSU beats IFU
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MASK_W  = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              busy
);

  localparam int unsigned       TMO_W    = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_grant;   // 1 = LSU owns the transaction, 0 = IFU
  logic [TMO_W-1:0]  r_timer;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;

  logic w_idle;
  logic w_lsu_win;
  logic w_ifu_win;
  logic w_accept;
  logic w_gnt_rsp_ready;
  logic w_tmo;

  assign w_idle = (r_state == S_IDLE);

`ifdef ARB_RR_EN
  logic r_last;   // master granted at the most recent accept (1 = LSU)

  // On contention the master that did not win last time goes first.
  assign w_lsu_win = lsu_req_valid && (!ifu_req_valid || !r_last);
`else
  // LSU first: the instruction in flight must finish before fetching ahead.
  assign w_lsu_win = lsu_req_valid;
`endif

  assign w_ifu_win       = ifu_req_valid && !w_lsu_win;
  assign w_accept        = w_idle && (ifu_req_valid || lsu_req_valid);
  assign w_gnt_rsp_ready = r_grant ? lsu_rsp_ready : ifu_rsp_ready;
  // Timer holds the number of cycles already spent in the state; this is the last one.
  assign w_tmo           = (r_timer == TMO_LAST);

  // State, grant, watchdog timer and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_timer <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
`ifdef ARB_RR_EN
      r_last  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_accept) begin
            r_grant <= w_lsu_win;
`ifdef ARB_RR_EN
            r_last  <= w_lsu_win;
`endif
            if (w_lsu_win) begin
              r_addr  <= lsu_req_addr;
              r_wen   <= lsu_req_wen;
              r_wdata <= lsu_req_wdata;
              r_wmask <= lsu_req_wen ? lsu_req_wmask : '0;
            end else begin
              r_addr  <= ifu_req_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // A handshake on the final cycle still wins over the timeout.
          if (mem_req_ready) begin
            r_timer <= '0;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_timer <= '0;
            r_state <= S_ERR;
          end else begin
            r_timer <= r_timer + TMO_W'(1);
          end
        end
        S_RESP: begin
          if (mem_rsp_valid && w_gnt_rsp_ready) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_timer <= '0;
            r_state <= S_ERR;
          end else begin
            r_timer <= r_timer + TMO_W'(1);
          end
        end
        S_ERR: begin
          r_timer <= '0;
          if (w_gnt_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_timer <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Request side: only the combinational winner sees ready, and only in IDLE.
  assign ifu_req_ready = w_idle && w_ifu_win;
  assign lsu_req_ready = w_idle && w_lsu_win;

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

  // Response side: pass the slave beat through to the granted master; in ERR
  // synthesize the error beat and keep draining any late slave response.
  assign ifu_rsp_valid = !r_grant &&
                         (((r_state == S_RESP) && mem_rsp_valid) || (r_state == S_ERR));
  assign lsu_rsp_valid = r_grant &&
                         (((r_state == S_RESP) && mem_rsp_valid) || (r_state == S_ERR));
  assign mem_rsp_ready = ((r_state == S_RESP) && w_gnt_rsp_ready) || (r_state == S_ERR);
  assign rsp_err       = (r_state == S_ERR);
  assign rsp_rdata     = (r_state == S_ERR)  ? ERR_DATA :
                         (r_state == S_RESP) ? mem_rsp_rdata : '0;

  assign busy = !w_idle;

endmodule
